serial_mag_comp: RTL and testbench
==================================

SERIAL_MAG_COMP -- requirements
Module: serial_mag_comp

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request to begin a comparison; accepted only in IDLE.
REQ-005 signed_mode  input  1  selects the comparison mode; 1 = two's-complement, 0 = unsigned; captured with start.
REQ-006 x  input  WIDTH  first operand; captured with start.
REQ-007 y  input  WIDTH  second operand; captured with start.
REQ-008 busy  output  1  high while a comparison is in progress.
REQ-009 done  output  1  one-cycle pulse marking a valid result.
REQ-010 gt  output  1  x > y.
REQ-011 lt  output  1  x < y.
REQ-012 eq  output  1  x == y.
REQ-013 bits_used  output  clog2(WIDTH+1)  number of bit positions examined for the last result.

Function
REQ-014 The block SHALL be a bit-serial, MSB-first successor of the cascaded greater/less slice: one bit position per clock, with early termination.
REQ-015 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-016 IDLE with start=1 at edge E0: capture x, y and signed_mode; set the bit index to WIDTH-1; clear the internal G/L; set busy=1; go to RUN.
REQ-017 RUN, per edge, compare bit index i: x[i]>y[i] sets gt; x[i]<y[i] sets lt.
REQ-018 In signed mode the MSB comparison SHALL be inverted: x[MSB]=1, y[MSB]=0 yields lt.
REQ-019 A decision (gt or lt) SHALL register gt/lt/eq, set done=1, set busy=0, load bits_used, and move to DONE.
REQ-020 With equal bits at i>0, the index SHALL decrement and the FSM SHALL remain in RUN.
REQ-021 With equal bits at i=0, eq=1 SHALL register and the FSM SHALL move to DONE.
REQ-022 Latency: the deciding bit j is evaluated at edge E(WIDTH-j); done is high for exactly the cycle following that edge; bits_used = WIDTH-j.
REQ-023 Worst-case latency SHALL be WIDTH cycles from start acceptance to done.
REQ-024 DONE SHALL return to IDLE on the next edge, with done=0.
REQ-025 gt/lt/eq/bits_used SHALL hold their values until the next start is accepted; on acceptance they SHALL clear to 0.
REQ-026 Exactly one of gt/lt/eq SHALL be high whenever done=1.
REQ-027 start SHALL be ignored in RUN and DONE, with no re-capture and no effect on the result in flight.
REQ-028 start held high continuously: a new comparison SHALL begin in the first IDLE cycle after DONE.
REQ-029 Changes on x/y/signed_mode after capture SHALL have no effect on the result.

Reset
REQ-030 reset=1 at any edge, including mid-RUN or in DONE, SHALL force IDLE and set busy=0, done=0, gt=0, lt=0, eq=0, bits_used=0, and clear the internal index and G/L.
REQ-031 reset SHALL take priority over start at the same edge.
REQ-032 The first start after reset deasserts SHALL behave exactly as a cold start.

Verification (WIDTH=8)
REQ-033 Unsigned x=0x80, y=0x7F -> gt=1 at E1, bits_used=1, done pulse of 1 cycle.
REQ-034 Signed x=0x80, y=0x7F -> lt=1 at E1, bits_used=1.
REQ-035 x=y=0x5A (either mode) -> eq=1 at E8, bits_used=8; busy is high for cycles E0..E7.
REQ-036 x=0x12, y=0x13 unsigned -> lt=1 at E8, bits_used=8.
REQ-037 Start pulsed again at E2 with x=0xFF, y=0x00 during the 0x12/0x13 run -> ignored; the result is still lt, bits_used=8.
REQ-038 reset asserted at E3 during x=y=0x00 -> at E4 every output is 0 and the FSM is in IDLE; a following start with x=0x01, y=0x00 -> gt at E8.

Source files
------------

// File: rtl/serial_mag_comp.sv
// ============================================================================
// serial_mag_comp : bit-serial MSB-first magnitude comparator, early exit
// Revision 1.0
// ============================================================================
`default_nettype none

module serial_mag_comp #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       signed_mode,
  input  logic [WIDTH-1:0]           x,
  input  logic [WIDTH-1:0]           y,
  output logic                       busy,
  output logic                       done,
  output logic                       gt,
  output logic                       lt,
  output logic                       eq,
  output logic [$clog2(WIDTH+1)-1:0] bits_used
);

  localparam int IW = $clog2(WIDTH);
  localparam int BW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic            sgn_q, sgn_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            gt_q, gt_d;
  logic            lt_q, lt_d;
  logic            eq_q, eq_d;
  logic [BW-1:0]   bits_q, bits_d;

  logic bit_x, bit_y, cmp_x, cmp_y, bit_gt, bit_lt, at_msb;

  always_comb begin
    bit_x  = x_q[idx_q];
    bit_y  = y_q[idx_q];
    at_msb = (idx_q == IW'(WIDTH - 1));
    // Two's-complement sign bit has negative weight, so its ordering flips.
    if (sgn_q && at_msb) begin
      cmp_x = bit_y;
      cmp_y = bit_x;
    end else begin
      cmp_x = bit_x;
      cmp_y = bit_y;
    end
    bit_gt = cmp_x & ~cmp_y;
    bit_lt = ~cmp_x & cmp_y;
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    sgn_d   = sgn_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    gt_d    = gt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    bits_d  = bits_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = x;
          y_d     = y;
          sgn_d   = signed_mode;
          idx_d   = IW'(WIDTH - 1);
          busy_d  = 1'b1;
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          eq_d    = 1'b0;
          bits_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bit_gt || bit_lt || (idx_q == '0)) begin
          gt_d    = bit_gt;
          lt_d    = bit_lt;
          eq_d    = ~(bit_gt | bit_lt);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          bits_d  = BW'(WIDTH) - BW'(idx_q);
          state_d = DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      sgn_q   <= 1'b0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      bits_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sgn_q   <= sgn_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      bits_q  <= bits_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign gt        = gt_q;
  assign lt        = lt_q;
  assign eq        = eq_q;
  assign bits_used = bits_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_mag_comp.sv
// ============================================================================
// tb_serial_mag_comp : directed self-checking bench for serial_mag_comp
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_serial_mag_comp;

  localparam int WIDTH = 8;
  localparam int BW    = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             signed_mode = 1'b0;
  logic [WIDTH-1:0] x = '0;
  logic [WIDTH-1:0] y = '0;
  logic             busy, done, gt, lt, eq;
  logic [BW-1:0]    bits_used;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  serial_mag_comp #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .signed_mode(signed_mode),
    .x          (x),
    .y          (y),
    .busy       (busy),
    .done       (done),
    .gt         (gt),
    .lt         (lt),
    .eq         (eq),
    .bits_used  (bits_used)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic b, input logic d,
                           input logic g, input logic l, input logic e,
                           input logic [31:0] bits);
    check({tag, ".busy"}, 32'(busy), 32'(b));
    check({tag, ".done"}, 32'(done), 32'(d));
    check({tag, ".gt"},   32'(gt),   32'(g));
    check({tag, ".lt"},   32'(lt),   32'(l));
    check({tag, ".eq"},   32'(eq),   32'(e));
    check({tag, ".bits"}, 32'(bits_used), bits);
  endtask

  task automatic launch(input logic sm, input logic [WIDTH-1:0] xv, input logic [WIDTH-1:0] yv);
    signed_mode = sm;
    x           = xv;
    y           = yv;
    start       = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    check_all("reset", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick();

    // Unsigned 0x80 vs 0x7F decides on the MSB; operands scrambled after capture.
    launch(1'b0, 8'h80, 8'h7F);
    check_all("u80_e0", 1, 0, 0, 0, 0, 0);
    x = 8'h00; y = 8'hFF; signed_mode = 1'b1;
    tick();
    check_all("u80_e1", 0, 1, 1, 0, 0, 1);
    tick();
    check_all("u80_e2", 0, 0, 1, 0, 0, 1);

    // Signed: 0x80 is -128, less than 127.
    launch(1'b1, 8'h80, 8'h7F);
    check_all("s80_e0", 1, 0, 0, 0, 0, 0);
    tick();
    check_all("s80_e1", 0, 1, 0, 1, 0, 1);
    tick();

    // Signed -1 vs +1.
    launch(1'b1, 8'hFF, 8'h01);
    tick();
    check_all("sff_e1", 0, 1, 0, 1, 0, 1);
    tick();

    // Equal operands run the full width.
    launch(1'b1, 8'h5A, 8'h5A);
    for (int i = 1; i < 8; i++) begin
      tick();
      check(i == 7 ? "eq_busy_e7" : "eq_busy", 32'(busy), 32'd1);
      check("eq_nodone", 32'(done), 32'd0);
    end
    tick();
    check_all("eq_e8", 0, 1, 0, 0, 1, 8);
    tick();
    check_all("eq_e9", 0, 0, 0, 0, 1, 8);

    // 0x12 vs 0x13 differs only at bit 0; restart at E2 must be ignored.
    launch(1'b0, 8'h12, 8'h13);
    tick();
    start = 1'b1; x = 8'hFF; y = 8'h00;
    tick();
    start = 1'b0;
    check("ign_busy_e2", 32'(busy), 32'd1);
    for (int i = 3; i < 8; i++) tick();
    check("lsb_nodone_e7", 32'(done), 32'd0);
    tick();
    check_all("lsb_e8", 0, 1, 0, 1, 0, 8);
    tick();

    // Reset mid-run at E3.
    launch(1'b0, 8'h00, 8'h00);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check_all("rst_e3", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick();
    check_all("rst_e4", 0, 0, 0, 0, 0, 0);
    launch(1'b0, 8'h01, 8'h00);
    for (int i = 1; i < 8; i++) tick();
    check("post_rst_nodone_e7", 32'(done), 32'd0);
    tick();
    check_all("post_rst_e8", 0, 1, 1, 0, 0, 8);
    tick();

    // Start held high: re-accepted in the first IDLE cycle after DONE.
    signed_mode = 1'b1; x = 8'h7F; y = 8'h80; start = 1'b1;
    tick();
    tick();
    check_all("hold_e1", 0, 1, 1, 0, 0, 1);
    tick();
    check_all("hold_e2", 0, 0, 1, 0, 0, 1);
    tick();
    check_all("hold_e3", 1, 0, 0, 0, 0, 0);
    start = 1'b0;
    tick();
    check_all("hold_e4", 0, 1, 1, 0, 0, 1);
    tick();
    tick();

    // Reset wins over start at the same edge.
    reset = 1'b1; start = 1'b1;
    tick();
    check_all("rst_prio", 0, 0, 0, 0, 0, 0);
    reset = 1'b0; start = 1'b0;
    tick();
    check("rst_prio_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

`default_nettype wire
